// File: rtl/quad_encoder_counter_if.sv
// Pin-side and register-side signals of the quadrature encoder counter.
// master = pin/register driver, slave = the counter itself.
interface quad_encoder_counter_if #(
    parameter int CNT_W = 32
);
    logic             enc_rstn;
    logic             enca;
    logic             encb;
    logic             encx;
    logic [1:0]       mode;
    logic             dir_invert;
    logic             index_clr_en;
    logic [CNT_W-1:0] position;
    logic [CNT_W-1:0] index_pos;
    logic             index_valid;
    logic             enc_udn;
    logic             enc_cas;
    logic             enc_err;
    logic             count_enable;
    logic             count_direction;

    modport master (
        output enc_rstn, enca, encb, encx, mode, dir_invert, index_clr_en,
        input  position, index_pos, index_valid, enc_udn, enc_cas, enc_err,
               count_enable, count_direction
    );

    modport slave (
        input  enc_rstn, enca, encb, encx, mode, dir_invert, index_clr_en,
        output position, index_pos, index_valid, enc_udn, enc_cas, enc_err,
               count_enable, count_direction
    );
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: synchroniser + glitch filter on A/B/X,
// x1/x2/x4 decode, wrapping position counter and index capture/clear.
module quad_encoder_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FLT_LEN     = 3
) (
    input  logic                   clk80m,
    input  logic                   resetn,
    quad_encoder_counter_if.slave  bus
);
    localparam int NCH      = 3;
    localparam int WARM_CYC = SYNC_STAGES + FLT_LEN + 1;
    localparam int WARM_W   = $clog2(WARM_CYC + 1);
    localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM_CYC);

    // Channel order inside the vectors: 0 = A, 1 = B, 2 = X.
    logic [NCH-1:0] pin_raw;
    logic [NCH-1:0] synced;
    logic [NCH-1:0] filt_q, filt_d;
    logic [NCH-1:0] prev_q, prev_d;

    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic              warm;

    logic [CNT_W-1:0] position_q, position_d;
    logic [CNT_W-1:0] index_pos_q, index_pos_d;
    logic             index_valid_q, index_valid_d;
    logic             enc_udn_q, enc_udn_d;
    logic             enc_cas_q, enc_cas_d;
    logic             enc_err_q, enc_err_d;
    logic             count_enable_q, count_enable_d;
    logic             count_direction_q, count_direction_d;

    logic a_chg, b_chg, raw_up, count_hit, idx_rise;

    assign pin_raw = {bus.encx, bus.encb, bus.enca};

    // Warm-up window: filtered levels track the synced pins with no events.
    assign warm       = (warm_cnt_q != WARM_END);
    assign warm_cnt_d = warm ? warm_cnt_q + WARM_W'(1) : warm_cnt_q;

    always_ff @(posedge clk80m or negedge resetn) begin
        if (!resetn) begin
            warm_cnt_q <= '0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [FLT_LEN-2:0]     hist_q, hist_d;
            logic                   stable;

            // hist holds the previous FLT_LEN-1 synced samples; with the current
            // synced bit that makes the FLT_LEN-sample agreement window.
            always_comb begin
                sync_d    = {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
                hist_d    = hist_q;
                hist_d[0] = sync_q[SYNC_STAGES-1];
                for (int i = 1; i < FLT_LEN - 1; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
            end

            assign synced[gi] = sync_q[SYNC_STAGES-1];
            assign stable     = (&{hist_q, synced[gi]}) | ~(|{hist_q, synced[gi]});
            assign filt_d[gi] = (warm || stable) ? synced[gi] : filt_q[gi];

            always_ff @(posedge clk80m or negedge resetn) begin
                if (!resetn) begin
                    sync_q <= '0;
                    hist_q <= '0;
                end else begin
                    sync_q <= sync_d;
                    hist_q <= hist_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk80m or negedge resetn) begin
        if (!resetn) begin
            filt_q <= '0;
            prev_q <= '0;
        end else begin
            filt_q <= filt_d;
            prev_q <= prev_d;
        end
    end

    // Decode compares the previous and current filtered levels. During warm-up
    // prev follows the fresh filtered value so no edge is seen on exit.
    always_comb begin
        prev_d = warm ? filt_d : filt_q;
        a_chg  = filt_q[0] ^ prev_q[0];
        b_chg  = filt_q[1] ^ prev_q[1];
        raw_up = a_chg ? (filt_q[0] ^ filt_q[1]) : ~(filt_q[0] ^ filt_q[1]);
        case (bus.mode)
            2'b01:   count_hit = a_chg & ~b_chg;
            2'b10:   count_hit = a_chg & ~b_chg & ~filt_q[1];
            default: count_hit = a_chg ^ b_chg;
        endcase
        idx_rise = ~warm & filt_q[2] & ~prev_q[2];
    end

    always_comb begin
        count_enable_d    = ~warm & count_hit;
        count_direction_d = ~warm & count_hit & (raw_up ^ bus.dir_invert);
        enc_err_d         = enc_err_q | (~warm & a_chg & b_chg);
        index_valid_d     = idx_rise;
        index_pos_d       = idx_rise ? position_q : index_pos_q;
        position_d        = position_q;
        enc_udn_d         = enc_udn_q;
        enc_cas_d         = enc_cas_q;

        // Index clear wins over a count landing in the same cycle.
        if (idx_rise && bus.index_clr_en) begin
            position_d = '0;
        end else if (count_enable_q) begin
            enc_udn_d = count_direction_q;
            if (count_direction_q) begin
                position_d = position_q + CNT_W'(1);
                if (&position_q) enc_cas_d = 1'b1;
            end else begin
                position_d = position_q - CNT_W'(1);
                if (~|position_q) enc_cas_d = 1'b1;
            end
        end

        if (!bus.enc_rstn) begin
            position_d        = '0;
            index_pos_d       = '0;
            index_valid_d     = 1'b0;
            enc_udn_d         = 1'b0;
            enc_cas_d         = 1'b0;
            enc_err_d         = 1'b0;
            count_enable_d    = 1'b0;
            count_direction_d = 1'b0;
        end
    end

    always_ff @(posedge clk80m or negedge resetn) begin
        if (!resetn) begin
            position_q        <= '0;
            index_pos_q       <= '0;
            index_valid_q     <= 1'b0;
            enc_udn_q         <= 1'b0;
            enc_cas_q         <= 1'b0;
            enc_err_q         <= 1'b0;
            count_enable_q    <= 1'b0;
            count_direction_q <= 1'b0;
        end else begin
            position_q        <= position_d;
            index_pos_q       <= index_pos_d;
            index_valid_q     <= index_valid_d;
            enc_udn_q         <= enc_udn_d;
            enc_cas_q         <= enc_cas_d;
            enc_err_q         <= enc_err_d;
            count_enable_q    <= count_enable_d;
            count_direction_q <= count_direction_d;
        end
    end

    assign bus.position        = position_q;
    assign bus.index_pos       = index_pos_q;
    assign bus.index_valid     = index_valid_q;
    assign bus.enc_udn         = enc_udn_q;
    assign bus.enc_cas         = enc_cas_q;
    assign bus.enc_err         = enc_err_q;
    assign bus.count_enable    = count_enable_q;
    assign bus.count_direction = count_direction_q;
endmodule
